// File: rtl/gpr_file.sv
// gpr_file: multi-port register file with write bypass and a pending-producer scoreboard.
// After reset a sweep zeroes one register per cycle; Ready rises once the sweep completes.
module gpr_file #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                WrClk,
    input  logic                rst,
    input  logic                RegWr,
    input  logic [AW-1:0]       Rw,
    input  logic [XLEN-1:0]     busW,
    input  logic [NRD*AW-1:0]   Ra,
    output logic [NRD*XLEN-1:0] busR,
    input  logic                SbSet,
    input  logic [AW-1:0]       SbRd,
    output logic [NRD-1:0]      Busy,
    output logic                Ready
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);
    state_t r_state, w_state_n;
    logic [AW-1:0] r_idx, w_idx_n;
    logic [XLEN-1:0] r_gpr [NREG];
    logic [NREG-1:0] r_pend;
    logic w_wr_ok, w_sb_ok;
    always_ff @(posedge WrClk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        if (r_state == CLEAR) begin
            w_state_n = (r_idx == LAST) ? RUN : CLEAR;
            w_idx_n   = (r_idx == LAST) ? '0 : r_idx + 1'b1;
        end
    end
    assign Ready   = r_state == RUN;
    assign w_wr_ok = Ready && RegWr && ({1'b0, Rw} < NREG_W) && !(ZERO_REG != 0 && Rw == '0);
    assign w_sb_ok = Ready && SbSet && ({1'b0, SbRd} < NREG_W) && !(ZERO_REG != 0 && SbRd == '0);
    // Set is assigned last so a same-edge write to the same index leaves it pending.
    always_ff @(posedge WrClk) begin
        if (!rst && r_state == CLEAR) begin
            r_gpr[r_idx]  <= '0;
            r_pend[r_idx] <= 1'b0;
        end else if (!rst) begin
            if (w_wr_ok) begin
                r_gpr[Rw]  <= busW;
                r_pend[Rw] <= 1'b0;
            end
            if (w_sb_ok) r_pend[SbRd] <= 1'b1;
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic w_ok, w_hit;
        assign w_ra  = Ra[k*AW +: AW];
        assign w_ok  = Ready && ({1'b0, w_ra} < NREG_W) && !(ZERO_REG != 0 && w_ra == '0);
        assign w_hit = w_wr_ok && Rw == w_ra;
        assign busR[k*XLEN +: XLEN] = !w_ok ? '0 : w_hit ? busW : r_gpr[w_ra];
        assign Busy[k] = w_ok && !w_hit && r_pend[w_ra];
    end
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: scoreboard bench driving a default instance and a 24x64, 3-port, no-zero-reg instance
// from shared stimulus, checked against an array-based reference model.
module tb_gpr_file;
    typedef struct packed {
        logic         r0;
        logic [1:0]   y0;
        logic [63:0]  b0;
        logic         r1;
        logic [2:0]   y1;
        logic [191:0] b1;
    } exp_t;
    logic clk = 1'b0;
    logic rst, RegWr, SbSet;
    logic [4:0] Rw, SbRd;
    logic [63:0] busW;
    logic [14:0] Ra;
    logic [63:0] busr0;
    logic [191:0] busr1;
    logic [1:0] busy0;
    logic [2:0] busy1;
    logic rdy0, rdy1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [63:0] m_gpr [2][32];
    bit m_pend [2][32];
    int m_cnt [2];
    bit known = 0;
    always #5 clk = ~clk;
    gpr_file u0 (
        .WrClk(clk), .rst(rst), .RegWr(RegWr), .Rw(Rw), .busW(busW[31:0]), .Ra(Ra[9:0]),
        .busR(busr0), .SbSet(SbSet), .SbRd(SbRd), .Busy(busy0), .Ready(rdy0)
    );
    gpr_file #(.XLEN(64), .NREG(24), .NRD(3), .ZERO_REG(0)) u1 (
        .WrClk(clk), .rst(rst), .RegWr(RegWr), .Rw(Rw), .busW(busW), .Ra(Ra),
        .busR(busr1), .SbSet(SbSet), .SbRd(SbRd), .Busy(busy1), .Ready(rdy1)
    );
    function automatic int nreg(int d);
        return d == 0 ? 32 : 24;
    endfunction
    function automatic bit zr(int d, logic [4:0] a);
        return d == 0 && a == 0;
    endfunction
    function automatic logic [63:0] mask(int d);
        return d == 0 ? 64'h0000_0000_FFFF_FFFF : '1;
    endfunction
    function automatic bit wleg(int d);
        return m_cnt[d] == 0 && RegWr && int'(Rw) < nreg(d) && !zr(d, Rw);
    endfunction
    function automatic bit sleg(int d);
        return m_cnt[d] == 0 && SbSet && int'(SbRd) < nreg(d) && !zr(d, SbRd);
    endfunction
    function automatic logic [64:0] rd(int d, logic [4:0] a);
        if (m_cnt[d] != 0 || int'(a) >= nreg(d) || zr(d, a)) return '0;
        if (wleg(d) && Rw == a) return {1'b0, busW & mask(d)};
        return {m_pend[d][a], m_gpr[d][a]};
    endfunction
    function automatic exp_t calc_exp();
        exp_t e;
        logic [64:0] v;
        e = '0;
        e.r0 = m_cnt[0] == 0;
        e.r1 = m_cnt[1] == 0;
        for (int k = 0; k < 2; k++) begin
            v = rd(0, Ra[k*5 +: 5]);
            e.y0[k] = v[64];
            e.b0[k*32 +: 32] = v[31:0];
        end
        for (int k = 0; k < 3; k++) begin
            v = rd(1, Ra[k*5 +: 5]);
            e.y1[k] = v[64];
            e.b1[k*64 +: 64] = v[63:0];
        end
        return e;
    endfunction
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_cnt[d] = nreg(d);
                for (int i = 0; i < 32; i++) begin
                    m_gpr[d][i] = '0;
                    m_pend[d][i] = 0;
                end
            end else if (m_cnt[d] > 0) begin
                m_cnt[d]--;
            end else begin
                if (wleg(d)) begin
                    m_gpr[d][Rw] = busW & mask(d);
                    m_pend[d][Rw] = 0;
                end
                if (sleg(d)) m_pend[d][SbRd] = 1;
            end
        end
        known = 1;
    endtask
    task automatic step(input logic r, input logic we, input logic [4:0] w, input logic [63:0] dat,
                        input logic [14:0] a, input logic ss, input logic [4:0] sr);
        rst = r; RegWr = we; Rw = w; busW = dat; Ra = a; SbSet = ss; SbRd = sr;
        if (known) q.push_back(calc_exp());
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic chk(input string n, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ready0", 192'(rdy0), 192'(e.r0));
            chk("busy0", 192'(busy0), 192'(e.y0));
            chk("busR0", 192'(busr0), 192'(e.b0));
            chk("ready1", 192'(rdy1), 192'(e.r1));
            chk("busy1", 192'(busy1), 192'(e.y1));
            chk("busR1", busr1, e.b1);
        end
    end
    function automatic logic [14:0] ra3(int a, int b, int c);
        return {5'(c), 5'(b), 5'(a)};
    endfunction
    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 64'h55, ra3(3, 0, 1), 1, 3);
        for (int i = 0; i < 33; i++)
            step(0, 1, 5'(i), {$urandom, $urandom}, ra3(i, i + 1, 31 - i), 1, 5'(i));
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, ra3(2 * i, 2 * i + 1, 31 - 2 * i), 0, 0);
        step(0, 1, 5, 64'hDEADBEEF, ra3(5, 6, 5), 0, 0);
        step(0, 0, 0, 0, ra3(5, 5, 5), 0, 0);
        step(0, 1, 0, 64'h1234, ra3(0, 0, 0), 0, 0);
        step(0, 0, 0, 0, ra3(0, 5, 0), 0, 0);
        step(0, 0, 0, 0, ra3(7, 0, 7), 1, 7);
        step(0, 0, 0, 0, ra3(7, 7, 7), 0, 0);
        step(0, 1, 7, 64'hA5A5_0000_1111_2222, ra3(7, 0, 7), 0, 0);
        step(0, 0, 0, 0, ra3(7, 7, 7), 0, 0);
        step(0, 1, 7, 64'h77, ra3(7, 1, 7), 1, 7);
        step(0, 0, 0, 0, ra3(7, 7, 7), 0, 0);
        step(0, 1, 30, 64'hCAFE_F00D_1234_5678, ra3(30, 30, 30), 1, 30);
        step(0, 0, 0, 0, ra3(30, 30, 30), 0, 0);
        step(0, 1, 9, 64'h9, ra3(9, 9, 9), 0, 0);
        step(0, 1, 10, 64'hA, ra3(9, 9, 9), 0, 0);
        step(0, 1, 11, 64'hB, ra3(9, 10, 11), 0, 0);
        step(0, 0, 0, 0, ra3(9, 10, 11), 0, 0);
        step(1, 1, 12, 64'hC, ra3(12, 9, 10), 1, 12);
        for (int i = 0; i < 10; i++)
            step(0, 1, 5'(i + 1), 64'hF0 + 64'(i), ra3(i + 1, i, 7), 1, 5'(i + 1));
        step(1, 1, 3, 64'h3, ra3(3, 4, 5), 0, 0);
        for (int i = 0; i < 33; i++)
            step(0, 1, 5'(i), 64'hBAD, ra3(i, 3, 2), 1, 5'(i));
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, ra3(2 * i, 2 * i + 1, 2 * i), 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(299) == 0, $urandom_range(1), 5'($urandom), {$urandom, $urandom},
                 15'($urandom), $urandom_range(2) == 0, 5'($urandom));
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
